// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter: shares one word-wide main-memory port between an icache
// (block refill) and a dcache (block refill and/or write-back). Each block is
// four 32-bit beats; every beat waits for mem_ack.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   ic_read, ic_address            icache refill request, block address
//   ic_readdata, ic_busywait       refilled block, icache stall
//   dc_read, dc_write, dc_address  dcache refill / write-back request, block address
//   dc_writedata                   write-back block (word0 in [31:0])
//   dc_readdata, dc_busywait       refilled block, dcache stall
//   mem_read, mem_write            main-memory word strobes
//   mem_address, mem_writedata     word address {block, beat}, write word
//   mem_readdata, mem_ack          read word, beat complete
module mem_refill_arbiter (
  input  logic         clk,
  input  logic         reset,
  input  logic         ic_read,
  input  logic [27:0]  ic_address,
  output logic [127:0] ic_readdata,
  output logic         ic_busywait,
  input  logic         dc_read,
  input  logic         dc_write,
  input  logic [27:0]  dc_address,
  input  logic [127:0] dc_writedata,
  output logic [127:0] dc_readdata,
  output logic         dc_busywait,
  output logic         mem_read,
  output logic         mem_write,
  output logic [29:0]  mem_address,
  output logic [31:0]  mem_writedata,
  input  logic [31:0]  mem_readdata,
  input  logic         mem_ack
);

  localparam int unsigned BlkW  = 28;
  localparam int unsigned WordW = 32;
  localparam int unsigned LineW = 128;
  localparam int unsigned BeatW = 2;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  typedef enum logic [2:0] {IDLE, IC_RD, DC_WR, DC_RD, DONE} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             rd_pend_q, rd_pend_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [BlkW-1:0]  addr_q, addr_d;
  logic [LineW-1:0] wblk_q, wblk_d;
  logic [LineW-1:0] ic_buf_q, ic_buf_d;
  logic [LineW-1:0] dc_buf_q, dc_buf_d;

  logic ic_req, dc_req, grant_dc, active;
  logic [6:0] word_lsb;

  assign word_lsb = {beat_q, 5'b0};
  assign active   = (state_q == IC_RD) || (state_q == DC_WR) || (state_q == DC_RD);

  // State, owner, beat, captured request and block buffers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IC;
      last_q    <= OWN_IC;
      rd_pend_q <= 1'b0;
      beat_q    <= '0;
      addr_q    <= '0;
      wblk_q    <= '0;
      ic_buf_q  <= '0;
      dc_buf_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      rd_pend_q <= rd_pend_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      wblk_q    <= wblk_d;
      ic_buf_q  <= ic_buf_d;
      dc_buf_q  <= dc_buf_d;
    end
  end

  // Arbitration, beat sequencing and buffer fill
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    rd_pend_d = rd_pend_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    wblk_d    = wblk_q;
    ic_buf_d  = ic_buf_q;
    dc_buf_d  = dc_buf_q;
    ic_req    = ic_read;
    dc_req    = dc_read | dc_write;
    grant_dc  = 1'b0;

    case (state_q)
      IDLE: begin
        if (ic_req || dc_req) begin
          grant_dc = dc_req && (!ic_req || (last_q == OWN_IC));
          // Round-robin memory only moves on a contested decision, so a client
          // served alone does not lose its turn at the next tie.
          if (ic_req && dc_req) last_d = grant_dc;
          owner_d = grant_dc;
          beat_d  = '0;
          if (grant_dc) begin
            addr_d    = dc_address;
            wblk_d    = dc_writedata;
            rd_pend_d = dc_read & dc_write;
            state_d   = dc_write ? DC_WR : DC_RD;
          end else begin
            addr_d  = ic_address;
            state_d = IC_RD;
          end
        end
      end
      IC_RD, DC_WR, DC_RD: begin
        if (mem_ack) begin
          if (state_q == IC_RD) ic_buf_d[word_lsb +: WordW] = mem_readdata;
          if (state_q == DC_RD) dc_buf_d[word_lsb +: WordW] = mem_readdata;
          beat_d = beat_q + BeatW'(1);
          if (beat_q == BeatW'(3)) begin
            if ((state_q == DC_WR) && rd_pend_q) begin
              // Write-back done; refill reuses the address register
              state_d   = DC_RD;
              addr_d    = dc_address;
              rd_pend_d = 1'b0;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_read      = (state_q == IC_RD) || (state_q == DC_RD);
  assign mem_write     = (state_q == DC_WR);
  assign mem_address   = active ? {addr_q, beat_q} : '0;
  assign mem_writedata = active ? wblk_q[word_lsb +: WordW] : '0;

  assign ic_readdata = ic_buf_q;
  assign dc_readdata = dc_buf_q;

  // Stall released only during the owner's DONE cycle
  assign ic_busywait = ic_read & ~((state_q == DONE) && (owner_q == OWN_IC));
  assign dc_busywait = (dc_read | dc_write) & ~((state_q == DONE) && (owner_q == OWN_DC));

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Bench for mem_refill_arbiter: per-cycle vector table for a plain icache
// refill and a dcache write-back+refill, then hand sequences for ack stall,
// round-robin arbitration and mid-transaction reset.
module tb_mem_refill_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         ic_read;
  logic [27:0]  ic_address;
  logic [127:0] ic_readdata;
  logic         ic_busywait;
  logic         dc_read, dc_write;
  logic [27:0]  dc_address;
  logic [127:0] dc_writedata;
  logic [127:0] dc_readdata;
  logic         dc_busywait;
  logic         mem_read, mem_write;
  logic [29:0]  mem_address;
  logic [31:0]  mem_writedata;
  logic [31:0]  mem_readdata;
  logic         mem_ack;

  int n_tot = 0;
  int n_bad = 0;

  mem_refill_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_read(ic_read), .ic_address(ic_address),
    .ic_readdata(ic_readdata), .ic_busywait(ic_busywait),
    .dc_read(dc_read), .dc_write(dc_write), .dc_address(dc_address),
    .dc_writedata(dc_writedata), .dc_readdata(dc_readdata), .dc_busywait(dc_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // Memory model: word n holds n*4 after reset, writes stored on acked edges
  logic [31:0] mem [256];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'(i * 4);
    end else if (mem_write && mem_ack) begin
      mem[mem_address[7:0]] <= mem_writedata;
    end
  end
  assign mem_readdata = mem[mem_address[7:0]];

  typedef struct {
    logic        ir;
    logic [27:0] ia;
    logic        dr, dw;
    logic [27:0] da;
    logic        ak;
    logic        er, ew;
    logic [29:0] ea;
    logic [31:0] ewd;
    logic        eib, edb;
  } vec_t;

  vec_t tv[16];

  function automatic vec_t mk(logic ir, logic [27:0] ia, logic dr, logic dw, logic [27:0] da,
                              logic ak, logic er, logic ew, logic [29:0] ea, logic [31:0] ewd,
                              logic eib, logic edb);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.ak = ak;
    v.er = er; v.ew = ew; v.ea = ea; v.ewd = ewd; v.eib = eib; v.edb = edb;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ic_read = 1'b0; ic_address = '0;
    dc_read = 1'b0; dc_write = 1'b0; dc_address = '0; dc_writedata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic chk_strobe(input string nm, input logic rd, input logic [29:0] a);
    chk({nm, " mem_read"}, 128'(mem_read), 128'(rd));
    chk({nm, " mem_write"}, 128'(mem_write), 128'(1'b0));
    chk({nm, " mem_address"}, 128'(mem_address), 128'(a));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    mem_ack = 1'b1;
    do_reset();

    // Reset state
    chk("rst mem_read", 128'(mem_read), 128'(1'b0));
    chk("rst mem_write", 128'(mem_write), 128'(1'b0));
    chk("rst mem_address", 128'(mem_address), 128'(30'h0));
    chk("rst mem_writedata", 128'(mem_writedata), 128'(32'h0));
    chk("rst ic_readdata", ic_readdata, 128'h0);
    chk("rst dc_readdata", dc_readdata, 128'h0);
    chk("rst ic_busywait", 128'(ic_busywait), 128'(1'b0));

    // icache refill of block 0x10, then dcache write-back+refill of block 0x2
    tv[0]  = mk(1'b1, 28'h10, 1'b0, 1'b0, 28'h0, 1'b1, 1'b1, 1'b0, 30'h40, 32'h0, 1'b1, 1'b0);
    tv[1]  = mk(1'b1, 28'h10, 1'b0, 1'b0, 28'h0, 1'b1, 1'b1, 1'b0, 30'h41, 32'h0, 1'b1, 1'b0);
    tv[2]  = mk(1'b1, 28'h10, 1'b0, 1'b0, 28'h0, 1'b1, 1'b1, 1'b0, 30'h42, 32'h0, 1'b1, 1'b0);
    tv[3]  = mk(1'b1, 28'h10, 1'b0, 1'b0, 28'h0, 1'b1, 1'b1, 1'b0, 30'h43, 32'h0, 1'b1, 1'b0);
    tv[4]  = mk(1'b1, 28'h10, 1'b0, 1'b0, 28'h0, 1'b1, 1'b0, 1'b0, 30'h0,  32'h0, 1'b0, 1'b0);
    tv[5]  = mk(1'b0, 28'h0,  1'b0, 1'b0, 28'h0, 1'b1, 1'b0, 1'b0, 30'h0,  32'h0, 1'b0, 1'b0);
    tv[6]  = mk(1'b0, 28'h0,  1'b1, 1'b1, 28'h2, 1'b1, 1'b0, 1'b1, 30'h8,  32'hAAAAAAAA, 1'b0, 1'b1);
    tv[7]  = mk(1'b0, 28'h0,  1'b1, 1'b1, 28'h2, 1'b1, 1'b0, 1'b1, 30'h9,  32'hBBBBBBBB, 1'b0, 1'b1);
    tv[8]  = mk(1'b0, 28'h0,  1'b1, 1'b1, 28'h2, 1'b1, 1'b0, 1'b1, 30'hA,  32'hCCCCCCCC, 1'b0, 1'b1);
    tv[9]  = mk(1'b0, 28'h0,  1'b1, 1'b1, 28'h2, 1'b1, 1'b0, 1'b1, 30'hB,  32'hDDDDDDDD, 1'b0, 1'b1);
    tv[10] = mk(1'b0, 28'h0,  1'b1, 1'b1, 28'h2, 1'b1, 1'b1, 1'b0, 30'h8,  32'h0, 1'b0, 1'b1);
    tv[11] = mk(1'b0, 28'h0,  1'b1, 1'b1, 28'h2, 1'b1, 1'b1, 1'b0, 30'h9,  32'h0, 1'b0, 1'b1);
    tv[12] = mk(1'b0, 28'h0,  1'b1, 1'b1, 28'h2, 1'b1, 1'b1, 1'b0, 30'hA,  32'h0, 1'b0, 1'b1);
    tv[13] = mk(1'b0, 28'h0,  1'b1, 1'b1, 28'h2, 1'b1, 1'b1, 1'b0, 30'hB,  32'h0, 1'b0, 1'b1);
    tv[14] = mk(1'b0, 28'h0,  1'b1, 1'b1, 28'h2, 1'b1, 1'b0, 1'b0, 30'h0,  32'h0, 1'b0, 1'b0);
    tv[15] = mk(1'b0, 28'h0,  1'b0, 1'b0, 28'h0, 1'b1, 1'b0, 1'b0, 30'h0,  32'h0, 1'b0, 1'b0);

    dc_writedata = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    for (int i = 0; i < 16; i++) begin
      ic_read = tv[i].ir; ic_address = tv[i].ia;
      dc_read = tv[i].dr; dc_write = tv[i].dw; dc_address = tv[i].da;
      mem_ack = tv[i].ak;
      step();
      chk($sformatf("v%0d mem_read", i), 128'(mem_read), 128'(tv[i].er));
      chk($sformatf("v%0d mem_write", i), 128'(mem_write), 128'(tv[i].ew));
      chk($sformatf("v%0d mem_address", i), 128'(mem_address), 128'(tv[i].ea));
      if (!tv[i].er) chk($sformatf("v%0d mem_writedata", i), 128'(mem_writedata), 128'(tv[i].ewd));
      chk($sformatf("v%0d ic_busywait", i), 128'(ic_busywait), 128'(tv[i].eib));
      chk($sformatf("v%0d dc_busywait", i), 128'(dc_busywait), 128'(tv[i].edb));
    end
    chk("tbl ic_readdata", ic_readdata, 128'h0000010C_00000108_00000104_00000100);
    chk("tbl dc_readdata", dc_readdata, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    idle_inputs();

    // Ack held low three cycles on beat 2: DONE at cycle 8
    ic_read = 1'b1; ic_address = 28'h20; mem_ack = 1'b1;
    step(); chk_strobe("stl b0", 1'b1, 30'h80);
    step(); chk_strobe("stl b1", 1'b1, 30'h81);
    step(); chk_strobe("stl b2", 1'b1, 30'h82);
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_strobe($sformatf("stl hold%0d", k), 1'b1, 30'h82);
      chk($sformatf("stl hold%0d busy", k), 128'(ic_busywait), 128'(1'b1));
    end
    mem_ack = 1'b1;
    step(); chk_strobe("stl b3", 1'b1, 30'h83);
    step();
    chk("stl done busy", 128'(ic_busywait), 128'(1'b0));
    chk("stl done mem_read", 128'(mem_read), 128'(1'b0));
    chk("stl data", ic_readdata, 128'h0000020C_00000208_00000204_00000200);
    idle_inputs();
    step();

    // Round-robin: dc first after reset, ic after; ic first on the next tie
    do_reset();
    chk("arb rst dc_readdata", dc_readdata, 128'h0);
    ic_read = 1'b1; ic_address = 28'h10; dc_read = 1'b1; dc_address = 28'h2;
    step(); chk_strobe("arb1 dc b0", 1'b1, 30'h8);
    chk("arb1 ic busy", 128'(ic_busywait), 128'(1'b1));
    step(); step(); step();
    chk_strobe("arb1 dc b3", 1'b1, 30'hB);
    step();
    chk("arb1 dc done", 128'(dc_busywait), 128'(1'b0));
    chk("arb1 ic still busy", 128'(ic_busywait), 128'(1'b1));
    chk("arb1 dc data", dc_readdata, 128'h0000002C_00000028_00000024_00000020);
    dc_read = 1'b0;
    step(); chk_strobe("arb1 idle", 1'b0, 30'h0);
    step(); chk_strobe("arb1 ic b0", 1'b1, 30'h40);
    step(); step(); step(); step();
    chk("arb1 ic done", 128'(ic_busywait), 128'(1'b0));
    chk("arb1 ic data", ic_readdata, 128'h0000010C_00000108_00000104_00000100);
    ic_read = 1'b0;
    step();
    ic_read = 1'b1; dc_read = 1'b1;
    step(); chk_strobe("arb2 ic b0", 1'b1, 30'h40);
    step(); step(); step(); step();
    chk("arb2 ic done", 128'(ic_busywait), 128'(1'b0));
    chk("arb2 dc busy", 128'(dc_busywait), 128'(1'b1));
    ic_read = 1'b0;
    step();
    step(); chk_strobe("arb2 dc b0", 1'b1, 30'h8);
    step(); step(); step(); step();
    chk("arb2 dc done", 128'(dc_busywait), 128'(1'b0));
    idle_inputs();
    step();

    // Reset during beat 1 of an icache refill
    ic_read = 1'b1; ic_address = 28'h10;
    step(); step();
    chk_strobe("rmid b1", 1'b1, 30'h41);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_strobe("rmid after", 1'b0, 30'h0);
    chk("rmid ic_readdata", ic_readdata, 128'h0);
    chk("rmid dc_readdata", dc_readdata, 128'h0);
    chk("rmid ic busy", 128'(ic_busywait), 128'(1'b1));
    step(); chk_strobe("rmid re b0", 1'b1, 30'h40);
    step(); step(); step(); step();
    chk("rmid re done", 128'(ic_busywait), 128'(1'b0));
    chk("rmid re data", ic_readdata, 128'h0000010C_00000108_00000104_00000100);
    idle_inputs();
    step();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_refill_arbiter.md
MEM_REFILL_ARBITER -- requirements
Module: mem_refill_arbiter

Interface
REQ-001 The block SHALL use one clock and synchronous active-high reset: clk, reset.
REQ-002 Ports (name  direction  width  meaning) SHALL be:
  clk  in  1  clock, all state changes on rising edge
  reset  in  1  synchronous active-high reset
  ic_read  in  1  icache block refill request
  ic_address  in  28  icache block address (byte addr[31:4])
  ic_readdata  out  128  refilled icache block, word0 in [31:0]
  ic_busywait  out  1  icache stall
  dc_read  in  1  dcache block refill request
  dc_write  in  1  dcache block write-back request
  dc_address  in  28  dcache block address
  dc_writedata  in  128  write-back block, word0 in [31:0]
  dc_readdata  out  128  refilled dcache block
  dc_busywait  out  1  dcache stall
  mem_read  out  1  main memory word read strobe
  mem_write  out  1  main memory word write strobe
  mem_address  out  30  word address {block, beat[1:0]}
  mem_writedata  out  32  write word
  mem_readdata  in  32  read word, valid when mem_ack high
  mem_ack  in  1  beat complete, sampled on clk edge

Function
REQ-003 FSM states SHALL be IDLE, IC_RD, DC_WR, DC_RD, DONE; owner flag (IC/DC) and 2-bit beat counter registered.
REQ-004 In IDLE, requests SHALL be sampled on the clk edge; a captured address and write block SHALL be held internally for the whole transaction.
REQ-005 Arbitration when ic and dc both request in IDLE: round-robin; grant goes to the client not granted last; after reset, dc has priority.
REQ-006 DC grant with dc_write=1 SHALL go to DC_WR; with dc_read only SHALL go to DC_RD; dc_write and dc_read both high SHALL do DC_WR then DC_RD (same address register reloaded from dc_address at DC_WR end) before DONE.
REQ-007 In IC_RD/DC_RD/DC_WR, mem_read or mem_write (exactly one) SHALL be high, mem_address={block,beat}, mem_writedata=block word[beat].
REQ-008 On an edge with mem_ack=1: read word SHALL be stored into buffer word[beat]; beat SHALL increment; on beat 3 the state SHALL advance (DC_WR->DC_RD if read pending, else DONE); beat resets to 0.
REQ-009 mem_ack=0 SHALL hold state, beat and strobes unchanged (unbounded wait).
REQ-010 DONE SHALL last exactly one cycle, then IDLE; requests SHALL be ignored in DONE.
REQ-011 ic_busywait SHALL be ic_read AND NOT (state==DONE AND owner==IC); dc_busywait SHALL be (dc_read OR dc_write) AND NOT (state==DONE AND owner==DC).
REQ-012 ic_readdata/dc_readdata SHALL be driven from the registered buffer and SHALL stay stable from DONE until that client's next grant.
REQ-013 Minimum latency with mem_ack tied high: request at cycle 0, strobes cycles 1-4, busywait low at cycle 5 (read or write); write+read: busywait low at cycle 9.
REQ-014 A request dropped mid-transaction SHALL NOT abort it; transfer completes, DONE occurs, data discarded by client.
REQ-015 mem_read and mem_write SHALL never be high simultaneously; both SHALL be low in IDLE and DONE.

Reset
REQ-016 reset=1 on an edge SHALL force IDLE, beat=0, last-grant=IC (dc priority next), clear buffers; outputs SHALL then be mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, readdata=0.
REQ-017 reset mid-transaction SHALL abort immediately; no further strobes; busywaits follow REQ-011 from IDLE.

Verification
REQ-018 ic_read=1, ic_address=28'h0000010, mem_ack=1, memory word n = n*4 -> mem_address 0x40..0x43 cycles 1-4, ic_busywait low cycle 5, ic_readdata=128'h0000010C_00000108_00000104_00000100.
REQ-019 dc_write=1, dc_read=1, dc_address=28'h0000002, dc_writedata=128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, mem_ack=1 -> writes AAAAAAAA..DDDDDDDD to 0x8..0xB, then reads 0x8..0xB, dc_busywait low cycle 9, readdata equals written block.
REQ-020 ic_read and dc_read both high from reset -> DC served first, IC second; repeat both -> IC served first (round-robin).
REQ-021 mem_ack held low 3 cycles on beat 2 -> strobes and mem_address constant 3 cycles, total latency 8, data correct.
REQ-022 reset asserted on beat 1 of IC_RD -> next cycle mem_read=0, state IDLE, ic_readdata=0; subsequent ic_read completes normally.
